// File: rtl/a_pkg.sv
// Shared definitions for the two-way four-phase arbiter.
package a_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    REL   = 3'd3,
    ACK   = 3'd4
  } state_t;

  // Active level of a handshake wire whose idle level is rpol.
  function automatic logic act_lvl(input logic rpol);
    return ~rpol;
  endfunction

endpackage

// File: rtl/a_sync.sv
// Two-flop synchronizer for one asynchronous handshake wire.
module a_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture then settle; both flops reset to the wire's idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/a_arb2.sv
// Two-requester round-robin arbiter onto one four-phase bundled-data channel.
module a_arb2
  import a_pkg::*;
#(
  parameter int   N    = 1,
  parameter logic Rpol = 1'b0,
  parameter int   T    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_i,
  output logic         a0_i,
  input  logic [N-1:0] d0_i,
  input  logic         r1_i,
  output logic         a1_i,
  input  logic [N-1:0] d1_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         gnt_o
);

  localparam logic       ACT    = act_lvl(Rpol);
  localparam logic [7:0] CNT_LD = 8'(T - 1);

  logic   r0_s, r1_s, a_s;
  logic   r0, r1, ak, rk, sel;
  logic   [7:0] cnt;
  state_t state;

  a_sync #(.RST_VAL(Rpol)) u_sync_r0 (.clk(clk), .rst(rst), .d(r0_i), .q(r0_s));
  a_sync #(.RST_VAL(Rpol)) u_sync_r1 (.clk(clk), .rst(rst), .d(r1_i), .q(r1_s));
  a_sync #(.RST_VAL(Rpol)) u_sync_a  (.clk(clk), .rst(rst), .d(a_o),  .q(a_s));

  // Internally everything is active-high regardless of Rpol.
  assign r0  = (r0_s == ACT);
  assign r1  = (r1_s == ACT);
  assign ak  = (a_s  == ACT);
  // Contention goes to whoever did not win last; otherwise the lone requester.
  assign sel = (r0 & r1) ? ~gnt_o : r1;
  assign rk  = gnt_o ? r1 : r0;

  // Arbitration and handshake sequencing; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r_o   <= Rpol;
      a0_i  <= Rpol;
      a1_i  <= Rpol;
      d_o   <= '0;
      gnt_o <= 1'b1;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0 | r1) begin
            gnt_o <= sel;
            d_o   <= sel ? d1_i : d0_i;
            cnt   <= CNT_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          // Data has been on d_o for T cycles when r_o goes active.
          if (cnt == 8'd0) begin
            r_o   <= ACT;
            state <= REQ;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        REQ: begin
          if (ak) begin
            r_o   <= Rpol;
            state <= REL;
          end
        end
        REL: begin
          if (!ak) begin
            if (gnt_o) a1_i <= ACT;
            else       a0_i <= ACT;
            state <= ACK;
          end
        end
        ACK: begin
          // A request dropped early simply finds this condition already true.
          if (!rk) begin
            a0_i  <= Rpol;
            a1_i  <= Rpol;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_arb2.sv
// Directed bench for a_arb2: one Rpol=0/T=2 instance, one Rpol=1/T=4 instance.
module tb_a_arb2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r0 = 1'b0, r1 = 1'b0, a_o = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       a0, a1, r_o, gnt_o;
  logic [7:0] d_o;

  logic       r0b = 1'b1, r1b = 1'b1, aob = 1'b1;
  logic [7:0] d0b = '0, d1b = '0;
  logic       a0b, a1b, rob, gntb;
  logic [7:0] dob;

  int errors = 0;
  int checks = 0;
  int dchg = 0;
  int both = 0;
  int a1_seen = 0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  always #5 clk = ~clk;

  a_arb2 #(.N(8), .Rpol(1'b0), .T(2)) dut0 (
    .clk(clk), .rst(rst), .r0_i(r0), .a0_i(a0), .d0_i(d0),
    .r1_i(r1), .a1_i(a1), .d1_i(d1), .r_o(r_o), .a_o(a_o),
    .d_o(d_o), .gnt_o(gnt_o));

  a_arb2 #(.N(8), .Rpol(1'b1), .T(4)) dut1 (
    .clk(clk), .rst(rst), .r0_i(r0b), .a0_i(a0b), .d0_i(d0b),
    .r1_i(r1b), .a1_i(a1b), .d1_i(d1b), .r_o(rob), .a_o(aob),
    .d_o(dob), .gnt_o(gntb));

  // Continuous protocol monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst && prev_r && (d_o !== prev_d)) dchg++;
    if (a0 && a1) both++;
    if (!a0b && !a1b) both++;
    if (a1) a1_seen++;
    prev_r = r_o;
    prev_d = d_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, limit 400000 reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get(input int s);
    case (s)
      0: return r_o;
      1: return a0;
      2: return a1;
      3: return rob;
      4: return a0b;
      5: return (d_o == 8'hA5);
      6: return (dob == 8'h5A);
      default: return 1'bx;
    endcase
  endfunction

  // Poll at negedges until the selected signal reaches lvl or the budget runs out.
  task automatic wait_for(input int s, input logic lvl, input int budget,
                          output int n, output logic got);
    n = 0;
    got = get(s);
    while (got !== lvl && n < budget) begin
      @(negedge clk);
      n++;
      got = get(s);
    end
  endtask

  // Act as the downstream stage for one transfer on dut0 and close the
  // upstream handshake of the expected winner.
  task automatic serve(input string tag, input logic [7:0] ed, input logic eg,
                       input bit rereq, input int hold);
    int n;
    int bad;
    logic got;
    wait_for(0, 1'b1, 60, n, got);
    chk({tag, "_rreq"}, 32'(got), 32'd1);
    chk({tag, "_d"}, 32'(d_o), 32'(ed));
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(eg));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (r_o !== 1'b1 || d_o !== ed || a0 !== 1'b0 || a1 !== 1'b0) bad++;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(bad), 32'd0);
    a_o = 1'b1;
    wait_for(0, 1'b0, 10, n, got);
    chk({tag, "_rrel"}, 32'(got), 32'd0);
    chk({tag, "_noack_early"}, 32'(a0 | a1), 32'd0);
    a_o = 1'b0;
    wait_for(1 + int'(eg), 1'b1, 10, n, got);
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_other_idle"}, 32'(eg ? a0 : a1), 32'd0);
    if (eg) r1 = 1'b0; else r0 = 1'b0;
    wait_for(1 + int'(eg), 1'b0, 10, n, got);
    chk({tag, "_ackrel"}, 32'(got), 32'd0);
    if (rereq) begin
      if (eg) r1 = 1'b1; else r0 = 1'b1;
    end
  endtask

  initial begin
    int n;
    logic got;

    // Reset state of both polarities.
    repeat (2) @(negedge clk);
    chk("rst_r_o", 32'(r_o), 32'd0);
    chk("rst_a0", 32'(a0), 32'd0);
    chk("rst_a1", 32'(a1), 32'd0);
    chk("rst_d_o", 32'(d_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd1);
    chk("rst_b_r_o", 32'(rob), 32'd1);
    chk("rst_b_acks", 32'({a0b, a1b}), 32'd3);
    chk("rst_b_d_o", 32'(dob), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, T=2 setup.
    a1_seen = 0;
    d0 = 8'hA5;
    r0 = 1'b1;
    wait_for(5, 1'b1, 10, n, got);
    chk("single_dload", 32'(got), 32'd1);
    chk("single_r_low_at_load", 32'(r_o), 32'd0);
    wait_for(0, 1'b1, 10, n, got);
    chk("single_setup_cycles", 32'(n), 32'd2);
    serve("single", 8'hA5, 1'b0, 1'b0, 0);
    chk("single_a1_never", 32'(a1_seen), 32'd0);

    // Rpol=1, T=4 instance.
    d0b = 8'h5A;
    r0b = 1'b0;
    wait_for(6, 1'b1, 10, n, got);
    chk("pol1_dload", 32'(got), 32'd1);
    wait_for(3, 1'b0, 10, n, got);
    chk("pol1_setup_cycles", 32'(n), 32'd4);
    aob = 1'b0;
    wait_for(3, 1'b1, 10, n, got);
    chk("pol1_rrel", 32'(got), 32'd1);
    aob = 1'b1;
    wait_for(4, 1'b0, 10, n, got);
    chk("pol1_ack", 32'(got), 32'd0);
    r0b = 1'b1;
    wait_for(4, 1'b1, 10, n, got);
    chk("pol1_ackrel", 32'(got), 32'd1);
    chk("pol1_a1_idle", 32'(a1b), 32'd1);

    // Contention straight after reset: requester 0 first.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d0 = 8'h11;
    d1 = 8'h22;
    r0 = 1'b1;
    r1 = 1'b1;
    serve("cont0", 8'h11, 1'b0, 1'b0, 0);
    serve("cont1", 8'h22, 1'b1, 1'b0, 0);

    // Fairness under continuous re-requests.
    d0 = 8'h33;
    d1 = 8'h44;
    r0 = 1'b1;
    r1 = 1'b1;
    serve("rr1", 8'h33, 1'b0, 1'b1, 0);
    serve("rr2", 8'h44, 1'b1, 1'b1, 0);
    serve("rr3", 8'h33, 1'b0, 1'b1, 0);
    serve("rr4", 8'h44, 1'b1, 1'b1, 0);
    serve("rr5", 8'h33, 1'b0, 1'b0, 0);
    serve("rr6", 8'h44, 1'b1, 1'b0, 0);

    // Slow downstream: ack withheld 50 cycles.
    d0 = 8'h77;
    r0 = 1'b1;
    serve("slow", 8'h77, 1'b0, 1'b0, 50);

    // Reset while r_o is active, then a pending requester 1.
    d0 = 8'h66;
    d1 = 8'h99;
    r0 = 1'b1;
    wait_for(0, 1'b1, 60, n, got);
    chk("mid_rreq", 32'(got), 32'd1);
    r1 = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_r_o", 32'(r_o), 32'd0);
    chk("mid_acks", 32'({a0, a1}), 32'd0);
    chk("mid_d_o", 32'(d_o), 32'd0);
    chk("mid_gnt", 32'(gnt_o), 32'd1);
    chk("mid_b_r_o", 32'(rob), 32'd1);
    repeat (2) @(negedge clk);
    r0 = 1'b0;
    rst = 1'b1;
    serve("post_rst", 8'h99, 1'b1, 1'b0, 0);

    repeat (4) @(negedge clk);
    chk("d_stable_while_r", 32'(dchg), 32'd0);
    chk("acks_exclusive", 32'(both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/a_arb2.md
A_ARB2 -- requirements
Module: a_arb2

Interface
REQ-001 Parameter N, default 32'b1, data width of every bundled-data channel.
REQ-002 Parameter Rpol, default 1'b0, idle/reset level of every request and acknowledge wire; the active level is ~Rpol.
REQ-003 Parameter T, default 32'd2, clock cycles of data setup before r_o goes active; legal range 1..255.
REQ-004 clk  input  1  single system clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 r0_i  input  1  requester 0 request (asynchronous to clk).
REQ-007 a0_i  output  1  requester 0 acknowledge.
REQ-008 d0_i  input  N  requester 0 bundled data, stable while r0_i is active.
REQ-009 r1_i, a1_i, d1_i: same as REQ-006..008 for requester 1.
REQ-010 r_o  output  1  request to the shared downstream stage.
REQ-011 a_o  input  1  acknowledge from the downstream stage (asynchronous to clk).
REQ-012 d_o  output  N  data to the downstream stage.
REQ-013 gnt_o  output  1  index of the current/last granted requester (0 or 1).

Function
REQ-014 All handshakes SHALL be four-phase: request active, acknowledge active, request idle, acknowledge idle.
REQ-015 r0_i, r1_i and a_o SHALL each pass through a two-flop synchronizer before any FSM use (2-cycle synchronizer latency).
REQ-016 FSM states SHALL be IDLE, SETUP, REQ, REL, ACK.
REQ-017 IDLE: with no synchronized request active, stay; with one active, grant it; with both active, grant the requester not equal to gnt_o (round-robin); go to SETUP.
REQ-018 On the IDLE->SETUP transition, d_o SHALL register the granted d_k, gnt_o SHALL update, and the setup counter SHALL load T-1.
REQ-019 SETUP: decrement counter each cycle; at zero assert r_o active and go to REQ (r_o active exactly T cycles after d_o changes).
REQ-020 REQ: hold r_o active; when synchronized a_o is active, drive r_o idle and go to REL.
REQ-021 REL: when synchronized a_o returns idle, drive a_k (granted requester) active and go to ACK.
REQ-022 ACK: hold a_k active; when synchronized r_k is idle, drive a_k idle and go to IDLE.
REQ-023 d_o SHALL hold its value from grant until the next grant; it SHALL never change while r_o is active.
REQ-024 A non-granted requester's acknowledge SHALL remain idle throughout; its pending request is served on the next IDLE evaluation.
REQ-025 At most one of a0_i, a1_i SHALL be active at any time.
REQ-026 A request going idle before being acknowledged (protocol violation) SHALL NOT abort an in-progress transfer; the FSM completes the downstream handshake.

Reset
REQ-027 On rst low, asynchronously: state IDLE, r_o = Rpol, a0_i = a1_i = Rpol, d_o = 0, gnt_o = 1 (so requester 0 wins first contention), counter 0, synchronizer flops = Rpol.
REQ-028 Reset asserted mid-transfer SHALL force REQ-027 values immediately; after release, arbitration restarts from IDLE with no residual grant.

Structure
REQ-029 State enumeration and the Rpol-relative active-level helper constant SHALL live in shared package a_pkg.
REQ-030 The two-flop synchronizer SHALL be one sub-module, a_sync, instantiated three times with reset value Rpol.

Verification
REQ-031 Single request: N=8, Rpol=0, T=2, d0_i=8'hA5, r0_i rises -> d_o=8'hA5 two cycles before r_o rises; after a_o rises r_o falls; after a_o falls a0_i rises; after r0_i falls a0_i falls; a1_i stays 0.
REQ-032 Contention after reset: r0_i and r1_i rise same cycle -> requester 0 served first (gnt_o=0), then requester 1 (gnt_o=1) with d_o changing only while r_o is low.
REQ-033 Fairness: both requesters re-request continuously for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-034 Rpol=1, T=4: all request/ack wires idle high after reset; r_o falls exactly 4 cycles after d_o loads.
REQ-035 Reset in REQ state: rst low while r_o active -> r_o, a0_i, a1_i return to Rpol asynchronously, d_o=0; after release, a pending r1_i is served normally.
REQ-036 Slow downstream: a_o held idle 50 cycles after r_o -> r_o stays active, d_o stable, no acknowledge to either requester.
